// File: rtl/sd_read_scheduler.sv
// Sequences an SD file reader through reset/retry/stream phases and buffers the
// byte stream in a FIFO toward a valid/ready UART transmitter.
module sd_read_scheduler #(
    parameter int unsigned FIFO_AW       = 10,
    parameter int unsigned RST_HOLD      = 1000,
    parameter int unsigned START_TIMEOUT = 200000000,
    parameter int unsigned IDLE_TIMEOUT  = 1000000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        reader_rstn,
    input  logic        file_found,
    input  logic        in_en,
    input  logic [7:0]  in_byte,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        overflow,
    output logic [3:0]  retry_cnt,
    output logic [31:0] byte_count
);

    localparam int unsigned AW    = FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_WAIT_FOUND, S_STREAM, S_DRAIN, S_DONE, S_FAIL
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    timer, timer_nxt;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic [7:0]     mem [DEPTH];
    logic [7:0]     head_nxt;
    logic           push, pop, drop, in_stream;
    logic           start_ok, retry_inc;

    // Session sequencing and the shared phase timer
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 32'd1;
        start_ok  = 1'b0;
        retry_inc = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (start) begin
                    state_nxt = S_HOLD;
                    start_ok  = 1'b1;
                end
            end
            S_HOLD: begin
                if (timer == 32'(RST_HOLD - 1)) begin
                    state_nxt = S_WAIT_FOUND;
                    timer_nxt = '0;
                end
            end
            S_WAIT_FOUND: begin
                if (file_found) begin
                    state_nxt = S_STREAM;
                    timer_nxt = '0;
                end else if (timer == 32'(START_TIMEOUT - 1)) begin
                    timer_nxt = '0;
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        state_nxt = S_HOLD;
                        retry_inc = 1'b1;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end
            end
            S_STREAM: begin
                if (in_en) begin
                    timer_nxt = '0;
                end else if (timer == 32'(IDLE_TIMEOUT - 1)) begin
                    state_nxt = S_DRAIN;
                    timer_nxt = '0;
                end
            end
            S_DRAIN: begin
                timer_nxt = '0;
                if (count == '0) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO control: fullness is judged before the same-cycle pop
    always_comb begin
        in_stream = (state == S_STREAM);
        push      = in_en && in_stream && (count != FULL);
        drop      = in_en && in_stream && (count == FULL);
        pop       = tx_en && tx_rdy;
        count_nxt = count + CW'(push) - CW'(pop);
        head_nxt  = tx_data;
        if (count_nxt == '0)
            head_nxt = tx_data;
        else if (count == '0 || (pop && count == CW'(1)))
            head_nxt = in_byte;
        else if (pop)
            head_nxt = mem[AW'(rd_ptr + AW'(1))];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_byte;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            timer       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            reader_rstn <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
            retry_cnt   <= '0;
            byte_count  <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            count       <= count_nxt;
            tx_data     <= head_nxt;
            tx_en       <= (count_nxt != '0);
            reader_rstn <= state_nxt inside {S_WAIT_FOUND, S_STREAM, S_DRAIN};
            busy        <= state_nxt inside {S_HOLD, S_WAIT_FOUND, S_STREAM, S_DRAIN};
            done        <= (state_nxt == S_DONE);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (start_ok) begin
                error      <= 1'b0;
                overflow   <= 1'b0;
                retry_cnt  <= '0;
                byte_count <= '0;
            end else begin
                if (state_nxt == S_FAIL) error <= 1'b1;
                if (drop) overflow <= 1'b1;
                if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
                if (push && byte_count != '1) byte_count <= byte_count + 32'd1;
            end
        end
    end

endmodule
